filter_sequencer: RTL and testbench
===================================

# filter_sequencer

Display-path controller between the image memory / filter chain and `vga_ctrl`. It debounces the four pushbuttons and uses them to pick the display source: original RGB, binary image, or dilated image. It also sets the binarisation threshold driven to `binary_convert`. All user changes are staged and committed only at a frame boundary, so no frame ever shows mixed settings.

## Interface
- `DEBOUNCE_CYCLES`, 250000: number of consecutive stable samples required to accept a key level (10 ms at 25 MHz).
- `THRESH_INIT`, 84: threshold value after reset and after a threshold-reset press.
- `THRESH_STEP`, 4: threshold increment/decrement per press.
- `THRESH_MAX`, 255: upper saturation limit for the threshold. The lower limit is 0.
- `clk`, in, 1: VGA pixel clock. Single clock domain.
- `rstn`, in, 1: asynchronous, active-low reset.
- `i_key_n`, in, 4: raw pushbuttons, active-low, asynchronous to `clk`.
  - [0] next mode
  - [1] threshold up
  - [2] threshold down
  - [3] threshold reset
- `i_frame_start`, in, 1: one-cycle pulse when the pixel counter is at (0,0).
- `i_red`, `i_green`, `i_blue`, in, 8 each: original pixel.
- `i_bin`, in, 10: binary-stage output. Nonzero means foreground.
- `i_dil`, in, 10: dilation-stage output. Nonzero means foreground.
- `o_red`, `o_green`, `o_blue`, out, 8 each: selected pixel, registered.
- `o_thresh`, out, 10: active threshold, connected to the binary stage `thresh`.
- `o_mode`, out, 2: active mode. 0 = ORIG, 1 = BIN, 2 = DIL. The value 3 is never output.
- `o_pending`, out, 1: high while the staged settings differ from the active settings (drives an LED).

## Operation
- **Key input path:** each key goes through a 2-flop synchronizer, then a per-key debounce counter.
  - The counter clears whenever the synchronized level differs from the accepted level.
  - When the counter reaches `DEBOUNCE_CYCLES`-1, the accepted level takes the synchronized level.
  - An accepted 1→0 transition produces a one-cycle press pulse. Releases produce no pulse. There is no auto-repeat.
- **Mode state machine (staged register):**
  - Transitions on a key[0] pulse: ORIG → BIN → DIL → ORIG.
  - Holds when there is no pulse.
- **Staged threshold:**
  - key[3] pulse: load `THRESH_INIT`. key[3] takes priority over key[1] and key[2].
  - key[1] pulse alone: add `THRESH_STEP`, saturating at `THRESH_MAX`.
  - key[2] pulse alone: subtract `THRESH_STEP`, saturating at 0.
  - key[1] and key[2] pulsing in the same cycle: no change.
  - The arithmetic is 11-bit internally, so the saturation check is overflow-free.
- **Commit:** on `i_frame_start`, the active mode/threshold registers load the staged values as they were *before* that cycle's key update.
  - A key pulse that coincides with `i_frame_start` therefore takes effect at the next frame.
- **Pixel mux (registered), controlled by the active mode:**
  - ORIG: pass `i_red`/`i_green`/`i_blue` through.
  - BIN: all three channels are 8'hFF if `i_bin` is nonzero, else 8'h00.
  - DIL: the same rule applied to `i_dil`.
- `o_pending` = (staged mode ≠ active mode) OR (staged threshold ≠ active threshold).

## Timing
- **Reset (asynchronous assert, synchronous deassert by the upstream reset-delay block):**
  - Staged and active mode = ORIG.
  - Staged and active threshold = `THRESH_INIT`.
  - `o_red`/`o_green`/`o_blue` = 0.
  - `o_pending` = 0.
  - Accepted key levels = 1 (released).
  - Debounce counters = 0.
- **Reset in mid-operation:** any staged-but-uncommitted change is lost. The first frame after reset shows ORIG.
- **Pixel latency:** 1 clock from the `i_*` inputs to `o_red`/`o_green`/`o_blue`. The mode select used in a given cycle is the active register value in that cycle.
- **Key latency:** a press is detected 2 (synchronizer) + `DEBOUNCE_CYCLES` cycles after a stable low at the pin; the staged register updates in the cycle after the pulse.
- **Commit latency:** `o_mode`/`o_thresh` change in the clock after the `i_frame_start` cycle. `o_pending` falls in that same clock unless a new change was staged concurrently.
- **Glitch rejection:** a bounce shorter than `DEBOUNCE_CYCLES` never produces a pulse.
- Repeated presses within one frame accumulate. Only the final staged value is committed.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `THRESH_STEP`=4, `THRESH_INIT`=84, `THRESH_MAX`=255.
- **Reset:** assert `rstn`=0 mid-frame after staging BIN → outputs 0, `o_mode`=0, `o_thresh`=84, `o_pending`=0. After release, `i_red`=8'h12 appears on `o_red` 1 cycle later.
- **Mode cycling:** three clean key[0] presses, each followed by a frame start → `o_mode` goes 1, 2, 0. In BIN with `i_bin`=10'h001 → RGB = FF/FF/FF; with `i_bin`=0 → RGB = 00/00/00.
- **Staging:** key[0] press with no frame start → `o_mode` stays 0 and `o_pending`=1. Pulse `i_frame_start` → `o_mode`=1 next clock and `o_pending`=0. A press whose pulse coincides with `i_frame_start` commits one frame later.
- **Threshold saturation:**
  - 45 key[1] presses → staged threshold 252, then 255 (holds at 255).
  - key[3] → 84.
  - 22 key[2] presses → 0 (holds at 0).
  - key[1]+key[2] pulses in the same cycle → unchanged.
- **Debounce:**
  - Low pulses of 3 cycles separated by 1-cycle highs for 40 cycles → no pulse.
  - Then a steady low → exactly one pulse.
  - Release bounce → no pulse.

Source files
------------

// File: rtl/filter_sequencer.sv
// filter_sequencer: display-path controller between the filter chain and vga_ctrl.
// Debounces four active-low pushbuttons. Uses them to stage a display mode
// (ORIG/BIN/DIL) and a binarisation threshold. Commits both at a frame boundary.
// Ports:
//   clk, rstn                 pixel clock, async active-low reset
//   i_key_n[3:0]              raw keys: [0] next mode, [1] thr up, [2] thr down, [3] thr reset
//   i_frame_start             one-cycle pulse at pixel (0,0)
//   i_red/i_green/i_blue      original pixel
//   i_bin, i_dil              binary / dilated stage output, nonzero = foreground
//   o_red/o_green/o_blue      selected pixel, registered
//   o_thresh                  active threshold
//   o_mode                    active mode (0 ORIG, 1 BIN, 2 DIL)
//   o_pending                 staged settings differ from active settings
module filter_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned THRESH_INIT     = 84,
  parameter int unsigned THRESH_STEP     = 4,
  parameter int unsigned THRESH_MAX      = 255
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [3:0] i_key_n,
  input  logic       i_frame_start,
  input  logic [7:0] i_red,
  input  logic [7:0] i_green,
  input  logic [7:0] i_blue,
  input  logic [9:0] i_bin,
  input  logic [9:0] i_dil,
  output logic [7:0] o_red,
  output logic [7:0] o_green,
  output logic [7:0] o_blue,
  output logic [9:0] o_thresh,
  output logic [1:0] o_mode,
  output logic       o_pending
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [9:0]  ThrInit = 10'(THRESH_INIT);
  localparam logic [10:0] ThrStep = 11'(THRESH_STEP);
  localparam logic [10:0] ThrMax  = 11'(THRESH_MAX);

  typedef enum logic [1:0] {
    ModeOrig = 2'd0,
    ModeBin  = 2'd1,
    ModeDil  = 2'd2
  } mode_e;

  // Key synchronizer and debounce
  logic [3:0]      key_s1_q, key_s2_q;
  logic [3:0]      level_q, level_d;
  logic [3:0]      press_q, press_d;
  logic [CntW-1:0] cnt_q [4];
  logic [CntW-1:0] cnt_d [4];

  // The counter runs only while the synchronized level disagrees with the accepted one,
  // so any sample agreeing with the accepted level restarts the stability window.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      cnt_d[k]   = cnt_q[k];
      level_d[k] = level_q[k];
      press_d[k] = 1'b0;
      if (key_s2_q[k] == level_q[k]) begin
        cnt_d[k] = '0;
      end else if (cnt_q[k] == CntLast) begin
        cnt_d[k]   = '0;
        level_d[k] = key_s2_q[k];
        press_d[k] = ~key_s2_q[k];
      end else begin
        cnt_d[k] = cnt_q[k] + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      key_s1_q <= 4'hF;
      key_s2_q <= 4'hF;
      level_q  <= 4'hF;
      press_q  <= 4'h0;
      for (int k = 0; k < 4; k++) cnt_q[k] <= '0;
    end else begin
      key_s1_q <= i_key_n;
      key_s2_q <= key_s1_q;
      level_q  <= level_d;
      press_q  <= press_d;
      for (int k = 0; k < 4; k++) cnt_q[k] <= cnt_d[k];
    end
  end

  // Staged mode FSM
  mode_e mode_stg_q, mode_stg_d, mode_act_q;

  always_comb begin
    mode_stg_d = mode_stg_q;
    if (press_q[0]) begin
      unique case (mode_stg_q)
        ModeOrig: mode_stg_d = ModeBin;
        ModeBin:  mode_stg_d = ModeDil;
        default:  mode_stg_d = ModeOrig;
      endcase
    end
  end

  // Staged threshold, 11-bit arithmetic so saturation compares never wrap
  logic [9:0]  thr_stg_q, thr_stg_d, thr_act_q;
  logic [10:0] thr_up, thr_dn;

  always_comb begin
    thr_up    = {1'b0, thr_stg_q} + ThrStep;
    thr_dn    = {1'b0, thr_stg_q} - ThrStep;
    thr_stg_d = thr_stg_q;
    if (press_q[3]) begin
      thr_stg_d = ThrInit;
    end else if (press_q[1] && !press_q[2]) begin
      thr_stg_d = (thr_up > ThrMax) ? ThrMax[9:0] : thr_up[9:0];
    end else if (press_q[2] && !press_q[1]) begin
      thr_stg_d = ({1'b0, thr_stg_q} < ThrStep) ? 10'd0 : thr_dn[9:0];
    end
  end

  // Active registers take the pre-update staged values, so a key pulse in the
  // frame-start cycle lands in the following frame.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mode_stg_q <= ModeOrig;
      mode_act_q <= ModeOrig;
      thr_stg_q  <= ThrInit;
      thr_act_q  <= ThrInit;
    end else begin
      mode_stg_q <= mode_stg_d;
      thr_stg_q  <= thr_stg_d;
      if (i_frame_start) begin
        mode_act_q <= mode_stg_q;
        thr_act_q  <= thr_stg_q;
      end
    end
  end

  // Registered pixel mux
  logic [7:0] red_d, green_d, blue_d;
  logic [7:0] red_q, green_q, blue_q;

  always_comb begin
    red_d   = i_red;
    green_d = i_green;
    blue_d  = i_blue;
    unique case (mode_act_q)
      ModeBin: begin
        red_d   = (|i_bin) ? 8'hFF : 8'h00;
        green_d = red_d;
        blue_d  = red_d;
      end
      ModeDil: begin
        red_d   = (|i_dil) ? 8'hFF : 8'h00;
        green_d = red_d;
        blue_d  = red_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      red_q   <= 8'h00;
      green_q <= 8'h00;
      blue_q  <= 8'h00;
    end else begin
      red_q   <= red_d;
      green_q <= green_d;
      blue_q  <= blue_d;
    end
  end

  assign o_red     = red_q;
  assign o_green   = green_q;
  assign o_blue    = blue_q;
  assign o_mode    = mode_act_q;
  assign o_thresh  = thr_act_q;
  assign o_pending = (mode_stg_q != mode_act_q) || (thr_stg_q != thr_act_q);

endmodule

// File: tb/tb_filter_sequencer.sv
module tb_filter_sequencer;

  logic       clk = 1'b0;
  logic       rstn;
  logic [3:0] key_n;
  logic       frame;
  logic [7:0] r, g, b;
  logic [9:0] bin, dil;
  logic [7:0] o_red, o_green, o_blue;
  logic [9:0] o_thresh;
  logic [1:0] o_mode;
  logic       o_pending;

  int errors = 0;
  int checks = 0;

  filter_sequencer #(
    .DEBOUNCE_CYCLES(4),
    .THRESH_INIT(84),
    .THRESH_STEP(4),
    .THRESH_MAX(255)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .i_key_n(key_n),
    .i_frame_start(frame),
    .i_red(r),
    .i_green(g),
    .i_blue(b),
    .i_bin(bin),
    .i_dil(dil),
    .o_red(o_red),
    .o_green(o_green),
    .o_blue(o_blue),
    .o_thresh(o_thresh),
    .o_mode(o_mode),
    .o_pending(o_pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Clean press: low long enough to be accepted, then a clean release.
  task automatic press(input int k);
    @(negedge clk) key_n[k] = 1'b0;
    cyc(10);
    key_n[k] = 1'b1;
    cyc(10);
  endtask

  task automatic frame_pulse();
    @(negedge clk) frame = 1'b1;
    @(negedge clk) frame = 1'b0;
  endtask

  task automatic check_rgb(input string tag, input logic [7:0] v);
    check({tag, "_r"}, o_red, v);
    check({tag, "_g"}, o_green, v);
    check({tag, "_b"}, o_blue, v);
  endtask

  initial begin
    rstn  = 1'b0;
    key_n = 4'hF;
    frame = 1'b0;
    r = 8'h00; g = 8'h00; b = 8'h00;
    bin = 10'h000; dil = 10'h000;
    #12;
    check_rgb("rst_rgb", 8'h00);
    check("rst_mode", o_mode, 2'd0);
    check("rst_thresh", o_thresh, 10'd84);
    check("rst_pending", o_pending, 1'b0);
    cyc(2);
    rstn = 1'b1;

    // ORIG passthrough, one cycle latency
    @(negedge clk) begin r = 8'h12; g = 8'h34; b = 8'h56; end
    @(negedge clk);
    check("orig_r", o_red, 8'h12);
    check("orig_g", o_green, 8'h34);
    check("orig_b", o_blue, 8'h56);

    // Staging then commit to BIN
    press(0);
    check("stage_mode", o_mode, 2'd0);
    check("stage_pend", o_pending, 1'b1);
    frame_pulse();
    check("commit_bin", o_mode, 2'd1);
    check("commit_pend", o_pending, 1'b0);
    bin = 10'h001;
    @(negedge clk);
    check_rgb("bin_fg", 8'hFF);
    bin = 10'h000;
    @(negedge clk);
    check_rgb("bin_bg", 8'h00);

    // DIL
    press(0);
    frame_pulse();
    check("commit_dil", o_mode, 2'd2);
    dil = 10'h200;
    @(negedge clk);
    check_rgb("dil_fg", 8'hFF);
    dil = 10'h000; bin = 10'h001;
    @(negedge clk);
    check_rgb("dil_bg", 8'h00);
    bin = 10'h000;

    // Back to ORIG
    press(0);
    frame_pulse();
    check("commit_orig", o_mode, 2'd0);
    @(negedge clk);
    check("orig2_r", o_red, 8'h12);

    // Press pulse coincides with frame start: commits one frame later.
    // Pin low at n0; pulse is high between the 6th and 7th rising edges.
    @(negedge clk) key_n[0] = 1'b0;
    cyc(6);
    check("coin_pre_pend", o_pending, 1'b0);
    frame = 1'b1;
    @(negedge clk) frame = 1'b0;
    check("coin_mode", o_mode, 2'd0);
    check("coin_pend", o_pending, 1'b1);
    key_n[0] = 1'b1;
    cyc(10);
    frame_pulse();
    check("coin_late_mode", o_mode, 2'd1);
    check("coin_late_pend", o_pending, 1'b0);

    // Threshold up to saturation: 84 + 42*4 = 252, further presses clamp at 255
    repeat (42) press(1);
    frame_pulse();
    check("thr_252", o_thresh, 10'd252);
    repeat (3) press(1);
    check("thr_sat_pend", o_pending, 1'b1);
    frame_pulse();
    check("thr_255", o_thresh, 10'd255);
    check("thr_255_pend", o_pending, 1'b0);

    press(3);
    frame_pulse();
    check("thr_reset", o_thresh, 10'd84);

    // Down to zero: 21 presses reach 0, one more holds
    repeat (21) press(2);
    frame_pulse();
    check("thr_0", o_thresh, 10'd0);
    press(2);
    check("thr_0_hold_pend", o_pending, 1'b0);
    frame_pulse();
    check("thr_0_hold", o_thresh, 10'd0);

    press(1);
    frame_pulse();
    check("thr_4", o_thresh, 10'd4);
    // Up and down in the same cycle cancel
    @(negedge clk) key_n[2:1] = 2'b00;
    cyc(10);
    key_n[2:1] = 2'b11;
    cyc(10);
    check("thr_both_pend", o_pending, 1'b0);
    frame_pulse();
    check("thr_both", o_thresh, 10'd4);

    // Debounce: 3-cycle lows with 1-cycle highs never accepted (mode is BIN here)
    for (int i = 0; i < 10; i++) begin
      key_n[0] = 1'b0;
      cyc(3);
      key_n[0] = 1'b1;
      cyc(1);
    end
    cyc(10);
    check("glitch_pend", o_pending, 1'b0);
    key_n[0] = 1'b0;
    cyc(12);
    check("steady_pend", o_pending, 1'b1);
    for (int i = 0; i < 10; i++) begin
      key_n[0] = 1'b1;
      cyc(3);
      key_n[0] = 1'b0;
      cyc(1);
    end
    key_n[0] = 1'b1;
    cyc(12);
    frame_pulse();
    check("one_pulse_mode", o_mode, 2'd2);
    check("one_pulse_pend", o_pending, 1'b0);

    // Reset mid-frame with BIN staged while DIL is active
    press(0);
    press(0);
    dil = 10'h001;
    @(negedge clk);
    check("pre_rst_pend", o_pending, 1'b1);
    check("pre_rst_r", o_red, 8'hFF);
    #2 rstn = 1'b0;
    #1;
    check_rgb("mid_rst_rgb", 8'h00);
    check("mid_rst_mode", o_mode, 2'd0);
    check("mid_rst_thresh", o_thresh, 10'd84);
    check("mid_rst_pend", o_pending, 1'b0);
    @(negedge clk) begin rstn = 1'b1; r = 8'h12; end
    @(negedge clk);
    check("post_rst_r", o_red, 8'h12);
    frame_pulse();
    check("post_rst_mode", o_mode, 2'd0);
    check("post_rst_pend", o_pending, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
